alu_sweep_driver: RTL

Sequential stimulus/response engine for the 2-bit ALU. It drives operands a1a0, b1b0 and opcode o1o2o3 through all 128 combinations, samples the ALU result c2c1c0 and the equality flag c3 for each one, and folds every sample into a 16-bit MISR signature. It sits next to the ALU as its in-hardware exerciser: its outputs feed the ALU inputs and the ALU outputs feed back to it. A single golden-signature compare replaces the simulation-only monitor.

---
 rtl/alu_sweep_driver.sv | 112 +++++++++++
 1 files changed

// File: rtl/alu_sweep_driver.sv
// In-hardware exerciser for the 2-bit ALU: steps all 128 operand/opcode vectors,
// folds each ALU response into a 16-bit MISR and compares it against a golden value.
module alu_sweep_driver #(
  parameter int          SETTLE = 1,
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] SEED   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] golden,
  output logic        a1,
  output logic        a0,
  output logic        b1,
  output logic        b0,
  output logic        o1,
  output logic        o2,
  output logic        o3,
  input  logic        c0,
  input  logic        c1,
  input  logic        c2,
  input  logic        c3,
  output logic        busy,
  output logic        done,
  output logic [15:0] sig,
  output logic        pass
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state_reg, state_next;
  logic [6:0]  idx_reg, idx_next;
  logic [3:0]  settle_reg, settle_next;
  logic [15:0] sig_reg, sig_next;
  logic [15:0] misr_next;
  logic [3:0]  resp;

  assign resp = {c3, c2, c1, c0};

  // One MISR step: shift left, fold POLY in when the MSB falls out, inject the response.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_misr
      if (gi == 0) begin : g_lsb
        assign misr_next[gi] = (sig_reg[15] & POLY[gi]) ^ resp[gi];
      end else if (gi < 4) begin : g_inject
        assign misr_next[gi] = sig_reg[gi-1] ^ (sig_reg[15] & POLY[gi]) ^ resp[gi];
      end else begin : g_shift
        assign misr_next[gi] = sig_reg[gi-1] ^ (sig_reg[15] & POLY[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      idx_reg    <= '0;
      settle_reg <= '0;
      sig_reg    <= SEED;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      settle_reg <= settle_next;
      sig_reg    <= sig_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    settle_next = settle_reg;
    sig_next    = sig_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next  = APPLY;
          idx_next    = '0;
          settle_next = '0;
          sig_next    = SEED;
        end
      end
      APPLY: begin
        settle_next = settle_reg + 4'd1;
        if (settle_reg == SETTLE_LAST) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        sig_next    = misr_next;
        settle_next = '0;
        // Last vector ends the sweep instead of wrapping idx back to 0.
        if (idx_reg == 7'd127) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 7'd1;
          state_next = APPLY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign {a1, a0, b1, b0, o1, o2, o3} = idx_reg;

  assign busy = (state_reg == APPLY) || (state_reg == SAMPLE);
  assign done = (state_reg == DONE);
  assign sig  = sig_reg;
  assign pass = done && (sig_reg == golden);

endmodule
